// File: rtl/ps2_cmd_ctrl.sv
// PS/2 keyboard front end for the Life game: line filtering, 11-bit framing, E0/F0 prefix tracking, command decode.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames that fail the odd-parity check.
module ps2_cmd_ctrl #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk_25mhz,
    input  logic       clr,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic       frame_err
);
    localparam int unsigned HIST_W = FILTER_LEN - 1;
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {F_IDLE, F_BITS, F_CHECK} frame_state_t;
    typedef enum logic [1:0] {P_NORM, P_EXT, P_BRK, P_EXTBRK} prefix_state_t;

    logic                  r_c_meta, r_c_sync, r_d_meta, r_d_sync;
    logic [HIST_W-1:0]     r_c_hist, r_d_hist;
    logic                  r_c_filt, r_d_filt, r_c_filt_d;
    frame_state_t          r_fstate;
    prefix_state_t         r_pstate;
    logic [10:0]           r_shift;
    logic [3:0]            r_bit_cnt;
    logic [WDOG_W-1:0]     r_wdog;

    logic [FILTER_LEN-1:0] w_c_win, w_d_win;
    logic                  w_strobe;
    logic [7:0]            w_byte;
    logic                  w_par_ok, w_frame_ok, w_ext, w_brk;
    logic [2:0]            w_map_cmd;

    // The window includes the newest synchronised sample so the level moves 2+FILTER_LEN cycles after the pin.
    assign w_c_win  = {r_c_hist, r_c_sync};
    assign w_d_win  = {r_d_hist, r_d_sync};
    assign w_strobe = r_c_filt_d & ~r_c_filt;

    // Frame layout after 11 LSB-first shifts: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
    assign w_byte = r_shift[8:1];
`ifdef PS2_PARITY_CHECK_EN
    assign w_par_ok = ^r_shift[9:1];
`else
    assign w_par_ok = 1'b1;
`endif
    assign w_frame_ok = ~r_shift[0] & r_shift[10] & w_par_ok;
    assign w_ext      = (r_pstate == P_EXT) || (r_pstate == P_EXTBRK);
    assign w_brk      = (r_pstate == P_BRK) || (r_pstate == P_EXTBRK);

    always_comb begin
        w_map_cmd = 3'd0;
        if (w_ext) begin
            case (w_byte)
                8'h75:   w_map_cmd = 3'd1;
                8'h72:   w_map_cmd = 3'd2;
                8'h6B:   w_map_cmd = 3'd3;
                8'h74:   w_map_cmd = 3'd4;
                default: w_map_cmd = 3'd0;
            endcase
        end else begin
            case (w_byte)
                8'h29:   w_map_cmd = 3'd5;
                8'h5A:   w_map_cmd = 3'd6;
                8'h21:   w_map_cmd = 3'd7;
                default: w_map_cmd = 3'd0;
            endcase
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (clr) begin
            r_c_meta   <= 1'b1;
            r_c_sync   <= 1'b1;
            r_d_meta   <= 1'b1;
            r_d_sync   <= 1'b1;
            r_c_hist   <= '1;
            r_d_hist   <= '1;
            r_c_filt   <= 1'b1;
            r_d_filt   <= 1'b1;
            r_c_filt_d <= 1'b1;
            r_fstate   <= F_IDLE;
            r_pstate   <= P_NORM;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_wdog     <= '0;
            key_valid  <= 1'b0;
            key_code   <= 8'h00;
            key_ext    <= 1'b0;
            key_break  <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd        <= 3'd0;
            frame_err  <= 1'b0;
        end else begin
            r_c_meta   <= PS2C;
            r_c_sync   <= r_c_meta;
            r_d_meta   <= PS2D;
            r_d_sync   <= r_d_meta;
            r_c_hist   <= w_c_win[HIST_W-1:0];
            r_d_hist   <= w_d_win[HIST_W-1:0];
            if (&w_c_win)       r_c_filt <= 1'b1;
            else if (~|w_c_win) r_c_filt <= 1'b0;
            if (&w_d_win)       r_d_filt <= 1'b1;
            else if (~|w_d_win) r_d_filt <= 1'b0;
            r_c_filt_d <= r_c_filt;

            key_valid <= 1'b0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;

            case (r_fstate)
                F_IDLE: begin
                    r_wdog <= '0;
                    if (w_strobe) begin
                        if (!r_d_filt) begin
                            r_shift   <= {r_d_filt, r_shift[10:1]};
                            r_bit_cnt <= 4'd1;
                            r_fstate  <= F_BITS;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                F_BITS: begin
                    if (w_strobe) begin
                        r_shift   <= {r_d_filt, r_shift[10:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_wdog    <= '0;
                        if (r_bit_cnt == 4'd10) r_fstate <= F_CHECK;
                    end else if (r_wdog == WDOG_W'(TIMEOUT_CYC - 1)) begin
                        frame_err <= 1'b1;
                        r_fstate  <= F_IDLE;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
                end
                F_CHECK: begin
                    r_fstate <= F_IDLE;
                    if (!w_frame_ok) begin
                        frame_err <= 1'b1;
                    end else if (w_byte == 8'hE0) begin
                        if (r_pstate == P_NORM) r_pstate <= P_EXT;
                    end else if (w_byte == 8'hF0) begin
                        if (r_pstate == P_NORM)     r_pstate <= P_BRK;
                        else if (r_pstate == P_EXT) r_pstate <= P_EXTBRK;
                    end else begin
                        key_valid <= 1'b1;
                        key_code  <= w_byte;
                        key_ext   <= w_ext;
                        key_break <= w_brk;
                        r_pstate  <= P_NORM;
                        // Releases never issue game commands.
                        if (!w_brk && (w_map_cmd != 3'd0)) begin
                            cmd_valid <= 1'b1;
                            cmd       <= w_map_cmd;
                        end
                    end
                end
                default: r_fstate <= F_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Scoreboard bench for ps2_cmd_ctrl: drives PS/2 frames, queues expected output events, checks them as they appear.
`timescale 1ns/1ps
module tb_ps2_cmd_ctrl;
    localparam int unsigned FILTER_LEN  = 8;
    localparam int unsigned TIMEOUT_CYC = 200;
    localparam int          HALF        = 20;
    localparam int          LAT         = 12;

    typedef struct {
        logic       err;
        logic       key;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       cv;
        logic [2:0] c;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic       key_valid, key_ext, key_break, cmd_valid, frame_err;
    logic [7:0] key_code;
    logic [2:0] cmd;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    ps2_cmd_ctrl #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk_25mhz (clk),
        .clr       (clr),
        .PS2C      (ps2c),
        .PS2D      (ps2d),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_break (key_break),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .frame_err (frame_err)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic err, input logic key, input logic [7:0] code,
                                input logic ext, input logic brk, input logic cv, input logic [2:0] c);
        exp_t e;
        e.err = err; e.key = key; e.code = code; e.ext = ext; e.brk = brk;
        e.cv = cv; e.c = c; e.cyc = 0;
        return e;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends the first nbits bits of a frame; the expected event is queued at the 11th falling edge.
    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic glitch,
                              input int nbits, input logic push, input exp_t e, output int last_fall);
        logic [10:0] bits;
        exp_t        q;
        bits = {1'b1, (~^b) ^ flip_par, b, 1'b0};
        q    = e;
        last_fall = 0;
        for (int i = 0; i < nbits; i++) begin
            ps2d = bits[i];
            if (glitch) begin
                wait_cyc(5);
                ps2c = 1'b0;
                wait_cyc(3);
                ps2c = 1'b1;
                wait_cyc(HALF - 8);
            end else begin
                wait_cyc(HALF);
            end
            ps2c = 1'b0;
            last_fall = cyc;
            if (i == 10 && push) begin
                q.cyc = cyc + LAT;
                exp_q.push_back(q);
            end
            wait_cyc(HALF);
            ps2c = 1'b1;
        end
        wait_cyc(HALF);
        ps2d = 1'b1;
    endtask

    always @(negedge clk) begin
        if (key_valid || cmd_valid || frame_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, frame_err, cmd_valid, key_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("frame_err", 32'(frame_err), 32'(mon_e.err));
                check("key_valid", 32'(key_valid), 32'(mon_e.key));
                check("cmd_valid", 32'(cmd_valid), 32'(mon_e.cv));
                check("event_cycle", 32'(cyc), 32'(mon_e.cyc));
                if (mon_e.key) begin
                    check("key_code", 32'(key_code), 32'(mon_e.code));
                    check("key_ext", 32'(key_ext), 32'(mon_e.ext));
                    check("key_break", 32'(key_break), 32'(mon_e.brk));
                end
                if (mon_e.cv) check("cmd", 32'(cmd), 32'(mon_e.c));
            end
        end
    end

    initial begin
        int   f;
        exp_t none;
        exp_t te;
        none = mk(0, 0, 8'h00, 0, 0, 0, 3'd0);

        wait_cyc(5);
        clr = 1'b0;
        wait_cyc(20);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_key_code", 32'(key_code), 32'd0);
        check("rst_key_ext", 32'(key_ext), 32'd0);
        check("rst_key_break", 32'(key_break), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);

        // Plain make code with a command.
        send_frame(8'h29, 0, 0, 11, 1, mk(0, 1, 8'h29, 0, 0, 1, 3'd5), f);

        // Extended make, then extended break.
        send_frame(8'hE0, 0, 0, 11, 0, none, f);
        send_frame(8'h75, 0, 0, 11, 1, mk(0, 1, 8'h75, 1, 0, 1, 3'd1), f);
        send_frame(8'hE0, 0, 0, 11, 0, none, f);
        send_frame(8'hF0, 0, 0, 11, 0, none, f);
        send_frame(8'h75, 0, 0, 11, 1, mk(0, 1, 8'h75, 1, 1, 0, 3'd0), f);

        // Corrupted parity bit.
`ifdef PS2_PARITY_CHECK_EN
        send_frame(8'h5A, 1, 0, 11, 1, mk(1, 0, 8'h00, 0, 0, 0, 3'd0), f);
`else
        send_frame(8'h5A, 1, 0, 11, 1, mk(0, 1, 8'h5A, 0, 0, 1, 3'd6), f);
`endif

        // Clock stalls after 5 bits; the watchdog fires TIMEOUT_CYC+1 cycles after the last strobe.
        send_frame(8'hA5, 0, 0, 5, 0, none, f);
        te     = mk(1, 0, 8'h00, 0, 0, 0, 3'd0);
        te.cyc = f + 10 + int'(TIMEOUT_CYC) + 1;
        exp_q.push_back(te);
        wait_cyc(int'(TIMEOUT_CYC) + 60);
        send_frame(8'h21, 0, 0, 11, 1, mk(0, 1, 8'h21, 0, 0, 1, 3'd7), f);

        // Short clock glitches must not create strobes.
        send_frame(8'h6B, 0, 1, 11, 1, mk(0, 1, 8'h6B, 0, 0, 0, 3'd0), f);

        // Reset in the middle of a frame after a break prefix.
        send_frame(8'hF0, 0, 0, 11, 0, none, f);
        send_frame(8'h29, 0, 0, 4, 0, none, f);
        wait_cyc(10);
        clr = 1'b1;
        wait_cyc(3);
        check("clr_key_code", 32'(key_code), 32'd0);
        check("clr_cmd", 32'(cmd), 32'd0);
        check("clr_key_break", 32'(key_break), 32'd0);
        check("clr_pulses", {29'd0, frame_err, cmd_valid, key_valid}, 32'd0);
        clr = 1'b0;
        wait_cyc(FILTER_LEN + 10);
        send_frame(8'h29, 0, 0, 11, 1, mk(0, 1, 8'h29, 0, 0, 1, 3'd5), f);

        wait_cyc(int'(TIMEOUT_CYC) + 50);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
